ram_1p_bus_adapter: RTL and testbench

RAM_1P_BUS_ADAPTER -- requirements
Module: ram_1p_bus_adapter

---
 rtl/ram_1p_pkg.sv | 24 ++
 rtl/ram_1p_bus_adapter.sv | 166 ++++++++++++++++
 tb/tb_ram_1p_bus_adapter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_1p_pkg.sv
// ---------------------------------------------------------------------------
// ram_1p_pkg
//   Shared types and constants for the single-port RAM bus adapter.
//   - state_e         : adapter FSM states (IDLE, WAIT, ACCESS)
//   - rsp_flags_t     : flags carried from the grant cycle to the response cycle
//   - MAX_WAIT_CYCLES : largest supported number of wait states (4-bit counter)
// ---------------------------------------------------------------------------
package ram_1p_pkg;

    localparam int unsigned MAX_WAIT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;     // a grant happened last cycle, respond now
        logic err;       // granted address fell outside the RAM window
        logic is_write;  // granted request was a write (respond with zero data)
    } rsp_flags_t;

endpackage

// File: rtl/ram_1p_bus_adapter.sv
// ---------------------------------------------------------------------------
// ram_1p_bus_adapter
//   Bridges a req/gnt/rvalid core data bus onto a registered single-port RAM.
//   Optional wait states are inserted before each grant; addresses outside
//   the [BASE_ADDR, BASE_ADDR + 4*SIZE) window are granted but answered with
//   an error and never reach the RAM.
//
// Parameters
//   BASE_ADDR   : byte address of RAM word 0
//   SIZE        : RAM depth in 32-bit words
//   AW          : RAM word-address width, clog2(SIZE)
//   WAIT_CYCLES : wait states before each grant, 0..MAX_WAIT_CYCLES
//
// Ports
//   clk_i, rst_ni          : clock (rising edge), async active-low reset
//   req_i / gnt_o          : core request and grant
//   we_i, be_i             : write enable and byte enables
//   addr_i, wdata_i        : byte address and write data
//   rvalid_o, rdata_o,err_o: response valid, read data, error flag
//   ram_valid_o            : RAM access strobe (grant cycle, in range only)
//   ram_addr_o             : RAM word address
//   ram_we_o, ram_wdata_o  : RAM byte write enables and write data
//   ram_rdata_i            : RAM read data, valid one cycle after ram_valid_o
// ---------------------------------------------------------------------------
module ram_1p_bus_adapter
    import ram_1p_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned SIZE        = 16384,
    parameter int unsigned AW          = 14,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          req_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          err_o,

    output logic          ram_valid_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_we_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);

    localparam logic [3:0]  WAIT_N      = 4'(WAIT_CYCLES);
    // One bit wider than the address so 4*SIZE == 2^32 is still representable.
    localparam logic [32:0] RANGE_BYTES = 33'(SIZE) << 2;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    rsp_flags_t rsp_q, rsp_d;

    logic [31:0] offset;
    logic        in_range;
    logic        gnt;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and therefore fail the range test without a separate lower-bound check.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < RANGE_BYTES;

    // -----------------------------------------------------------------------
    // Next-state / grant logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (WAIT_N == 4'd0) begin
                        gnt     = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = WAIT_N;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!req_i) begin
                    // Master abandoned the request: drop it silently.
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    // The counter reaches zero on this decrement, so the
                    // grant lands after exactly WAIT_N stalled cycles.
                    gnt     = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ACCESS: begin
                if (req_i) begin
                    if (WAIT_N == 4'd0) begin
                        gnt = 1'b1;     // full throughput, stay in ACCESS
                    end else begin
                        cnt_d   = WAIT_N;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase

        rsp_d.valid    = gnt;
        rsp_d.err      = ~in_range;
        rsp_d.is_write = we_i;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rsp_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // values present before the edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The grant is combinational from req_i, so it is gated by reset to keep
    // the bus and RAM quiet while rst_ni is low.
    assign gnt_o       = gnt & rst_ni;

    assign ram_valid_o = gnt_o & in_range;
    assign ram_we_o    = (ram_valid_o & we_i) ? be_i : 4'b0000;
    assign ram_addr_o  = offset[AW+1:2];
    assign ram_wdata_o = wdata_i;

    assign rvalid_o    = rsp_q.valid;
    assign err_o       = rsp_q.valid & rsp_q.err;
    assign rdata_o     = (rsp_q.valid & ~rsp_q.err & ~rsp_q.is_write) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_1p_bus_adapter.sv
// ---------------------------------------------------------------------------
// tb_ram_1p_bus_adapter
//   Two adapter instances share clock and reset:
//     dut0 : WAIT_CYCLES=0, BASE_ADDR=0,           SIZE=1024
//     dut1 : WAIT_CYCLES=3, BASE_ADDR=0x0010_0000, SIZE=1024
//   Each drives its own registered RAM stub. A shadow memory plus a response
//   queue per instance predicts grant latency, RAM strobes and responses.
// ---------------------------------------------------------------------------
module tb_ram_1p_bus_adapter;

    localparam int unsigned SIZE = 1024;
    localparam int unsigned AW   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req[2], gnt[2], rvalid[2], we[2], err[2], ram_valid[2];
    logic [3:0]    be[2], ram_we[2];
    logic [31:0]   addr[2], wdata[2], rdata[2], ram_wdata[2], ram_rdata[2];
    logic [AW-1:0] ram_addr[2];

    ram_1p_bus_adapter #(
        .BASE_ADDR(32'h0000_0000), .SIZE(SIZE), .AW(AW), .WAIT_CYCLES(0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .err_o(err[0]),
        .ram_valid_o(ram_valid[0]), .ram_addr_o(ram_addr[0]), .ram_we_o(ram_we[0]),
        .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0])
    );

    ram_1p_bus_adapter #(
        .BASE_ADDR(32'h0010_0000), .SIZE(SIZE), .AW(AW), .WAIT_CYCLES(3)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .err_o(err[1]),
        .ram_valid_o(ram_valid[1]), .ram_addr_o(ram_addr[1]), .ram_we_o(ram_we[1]),
        .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1])
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'h0010_0000;
    endfunction

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic bit in_rng(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(i);
        return off < 4 * SIZE;
    endfunction

    // Reference model state
    logic [31:0]   shadow[2][SIZE];
    logic [31:0]   mem[2][SIZE];
    logic [32:0]   exp_q0[$];          // {err, rdata}
    logic [32:0]   exp_q1[$];
    int            last_lat[2], grant_cyc[2], access_cnt[2], rvalid_cnt[2];
    int            cyc_cnt = 0;
    logic [31:0]   last_rdata[2];
    logic          last_err[2];
    logic [AW-1:0] snap_addr[2];
    logic [3:0]    snap_we[2];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- RAM stubs (registered read, byte writes) ----------------
    // The request is captured at the falling edge so the stub never races
    // with the adapter's own state update on the rising edge.
    initial begin
        logic          pv[2];
        logic [AW-1:0] pa[2];
        logic [3:0]    pw[2];
        logic [31:0]   pd[2];
        for (int i = 0; i < 2; i++) ram_rdata[i] = 32'h0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                pv[i] = ram_valid[i]; pa[i] = ram_addr[i];
                pw[i] = ram_we[i];    pd[i] = ram_wdata[i];
            end
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pv[i]) begin
                    access_cnt[i]++;
                    for (int b = 0; b < 4; b++)
                        if (pw[i][b]) mem[i][pa[i]][8*b +: 8] = pd[i][8*b +: 8];
                    ram_rdata[i] = mem[i][pa[i]];
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge; returns one step after the grant edge.
    task automatic do_req(input int i, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        int          cyc;
        bit          done;
        logic [31:0] off, v;
        logic [32:0] e;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (gnt[i]) begin
                done = 1'b1;
                check($sformatf("grant_latency[%0d]", i), cyc, wait_of(i) + 1);
                last_lat[i]  = cyc;
                grant_cyc[i] = cyc_cnt;
                snap_addr[i] = ram_addr[i];
                snap_we[i]   = ram_we[i];
                off = a - base_of(i);
                if (!in_rng(i, a)) begin
                    e = {1'b1, 32'h0};
                end else if (w) begin
                    v = shadow[i][off[AW+1:2]];
                    for (int k = 0; k < 4; k++)
                        if (b[k]) v[8*k +: 8] = d[8*k +: 8];
                    shadow[i][off[AW+1:2]] = v;
                    e = {1'b0, 32'h0};
                end else begin
                    e = {1'b0, shadow[i][off[AW+1:2]]};
                end
                if (i == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end else if (cyc > 40) begin
                done = 1'b1;
                check($sformatf("grant_timeout[%0d]", i), cyc, wait_of(i) + 1);
            end
            align();
        end
        req[i] = 1'b0;
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic        prev_gnt[2];
        logic        exp_v, have;
        logic [3:0]  ew;
        logic [31:0] off;
        logic [32:0] e;
        prev_gnt[0] = 1'b0;
        prev_gnt[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    check("rst_gnt",       32'(gnt[i]),       0);
                    check("rst_rvalid",    32'(rvalid[i]),    0);
                    check("rst_err",       32'(err[i]),       0);
                    check("rst_rdata",     rdata[i],          0);
                    check("rst_ram_valid", 32'(ram_valid[i]), 0);
                    check("rst_ram_we",    32'(ram_we[i]),    0);
                    prev_gnt[i] = 1'b0;
                    if (i == 0) exp_q0.delete();
                    else        exp_q1.delete();
                end else begin
                    if (!req[i]) check($sformatf("gnt_without_req[%0d]", i), 32'(gnt[i]), 0);

                    exp_v = gnt[i] && in_rng(i, addr[i]);
                    ew    = (exp_v && we[i]) ? be[i] : 4'b0000;
                    check($sformatf("ram_valid[%0d]", i), 32'(ram_valid[i]), 32'(exp_v));
                    check($sformatf("ram_we[%0d]", i),    32'(ram_we[i]),    32'(ew));
                    if (exp_v) begin
                        off = addr[i] - base_of(i);
                        check($sformatf("ram_addr[%0d]", i),  32'(ram_addr[i]), 32'(off[AW+1:2]));
                        check($sformatf("ram_wdata[%0d]", i), ram_wdata[i], wdata[i]);
                    end

                    check($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'(prev_gnt[i]));
                    if (rvalid[i]) begin
                        rvalid_cnt[i]++;
                        last_rdata[i] = rdata[i];
                        last_err[i]   = err[i];
                        have = 1'b0;
                        e    = '0;
                        if (i == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                        if (i == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            check($sformatf("rsp_unexpected[%0d]", i), 32'(rvalid[i]), 0);
                        end else begin
                            check($sformatf("rdata[%0d]", i), rdata[i],      e[31:0]);
                            check($sformatf("err[%0d]", i),   32'(err[i]),   32'(e[32]));
                        end
                    end else begin
                        check($sformatf("idle_rdata[%0d]", i), rdata[i],    0);
                        check($sformatf("idle_err[%0d]", i),   32'(err[i]), 0);
                    end
                    prev_gnt[i] = gnt[i];
                end
            end
        end
    end

    // ---------------- randomized traffic ----------------
    task automatic rand_run(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            int          g, r;
            logic [31:0] a;
            g = $urandom_range(0, 2);
            repeat (g) align();
            r = $urandom_range(0, 9);
            if (r == 0)      a = base_of(i) + 4 * SIZE + $urandom_range(0, 255);
            else if (r == 1) a = base_of(i) - 1 - $urandom_range(0, 255);
            else             a = base_of(i) + $urandom_range(0, SIZE * 4 - 1);
            do_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a0, rc, first;
        logic [31:0] v;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
            for (int w = 0; w < int'(SIZE); w++) begin
                v = $urandom;
                shadow[i][w] = v;
                mem[i][w]    = v;
            end
        end
        shadow[0][4] = 32'hDEAD_BEEF; mem[0][4] = 32'hDEAD_BEEF;
        shadow[0][2] = 32'hAABB_CCDD; mem[0][2] = 32'hAABB_CCDD;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        align();

        // Zero-wait read of word 4
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
        check("d_read_latency", last_lat[0], 1);
        check("d_read_ram_addr", 32'(snap_addr[0]), 4);
        @(negedge clk); #1;
        check("d_read_rdata", last_rdata[0], 32'hDEAD_BEEF);
        check("d_read_err", 32'(last_err[0]), 0);
        align();

        // Partial write then read-back
        do_req(0, 1'b1, 4'b0101, 32'h8, 32'h1122_3344);
        check("d_write_ram_we", 32'(snap_we[0]), 32'h5);
        do_req(0, 1'b0, 4'h0, 32'h8, 32'h0);
        @(negedge clk); #1;
        check("d_partial_write_readback", last_rdata[0], 32'hAA22_CC44);
        align();

        // Eight back-to-back reads
        rc = rvalid_cnt[0];
        first = 0;
        for (int k = 0; k < 8; k++) begin
            do_req(0, 1'b0, 4'h0, 32'(k * 4), 32'h0);
            if (k == 0) first = grant_cyc[0];
        end
        check("d_b2b_grant_span", grant_cyc[0] - first, 7);
        @(negedge clk); #1;
        check("d_b2b_rvalid_count", rvalid_cnt[0] - rc, 8);
        align();

        // Three wait states, one RAM access
        a0 = access_cnt[1];
        do_req(1, 1'b0, 4'h0, 32'h0010_0010, 32'h0);
        check("d_wait3_latency", last_lat[1], 4);
        @(negedge clk); #1;
        check("d_wait3_access_count", access_cnt[1] - a0, 1);
        check("d_wait3_rdata", last_rdata[1], shadow[1][4]);
        align();

        // Out-of-range above and below the window
        a0 = access_cnt[1];
        do_req(1, 1'b0, 4'h0, 32'h0010_1000, 32'h0);
        @(negedge clk); #1;
        check("d_oor_hi_err", 32'(last_err[1]), 1);
        check("d_oor_hi_rdata", last_rdata[1], 0);
        align();
        do_req(1, 1'b1, 4'hF, 32'h000F_FFFC, 32'h1234_5678);
        @(negedge clk); #1;
        check("d_oor_lo_err", 32'(last_err[1]), 1);
        check("d_oor_lo_rdata", last_rdata[1], 0);
        check("d_oor_access_count", access_cnt[1] - a0, 0);
        align();

        // Request abandoned during wait states
        a0 = access_cnt[1];
        rc = rvalid_cnt[1];
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0010_0020;
        align(); align();
        req[1] = 1'b0;
        repeat (4) align();
        check("d_abandon_access_count", access_cnt[1] - a0, 0);
        check("d_abandon_rvalid_count", rvalid_cnt[1] - rc, 0);
        do_req(1, 1'b0, 4'h0, 32'h0010_0020, 32'h0);
        align();

        // Write with no byte enables
        do_req(0, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("d_be0_err", 32'(last_err[0]), 0);
        align();
        do_req(0, 1'b0, 4'h0, 32'h20, 32'h0);
        @(negedge clk); #1;
        check("d_be0_readback", last_rdata[0], mem[0][8]);
        align();

        // Reset between grant and response
        rc = rvalid_cnt[0];
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
        rst_n = 1'b0;
        align();
        rst_n = 1'b1;
        repeat (3) align();
        check("d_reset_drops_rsp", rvalid_cnt[0] - rc, 0);
        do_req(0, 1'b0, 4'h0, 32'h14, 32'h0);
        @(negedge clk); #1;
        check("d_after_reset_rdata", last_rdata[0], shadow[0][5]);
        check("d_after_reset_rvalid_count", rvalid_cnt[0] - rc, 1);
        align();

        // Randomized traffic on both instances in parallel
        fork
            rand_run(0, 200);
            rand_run(1, 150);
        join
        repeat (3) align();
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
